// File: rtl/glm_framebuffer_if.sv
// Bus bundle between the GLM framebuffer and its pixel source / scan driver.
// The master modport is the pixel source and scan driver side; the slave modport is the framebuffer.
interface glm_framebuffer_if #(
  parameter int COLS = 32,
  parameter int ROWS = 16
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS / 2);

  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_data;
  logic          wr_last;
  logic          frame_sync;
  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [5:0]    rd_data;
  logic          rd_valid;
  logic          swap;
  logic          err;

  modport master (
    output wr_valid, wr_data, wr_last, frame_sync, rd_en, rd_row, rd_col,
    input  wr_ready, rd_data, rd_valid, swap, err
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, frame_sync, rd_en, rd_row, rd_col,
    output wr_ready, rd_data, rd_valid, swap, err
  );
endinterface

// File: rtl/glm_framebuffer.sv
// Double-buffered GLM frame store: raster pixel stream fills the back bank,
// scan driver reads upper/lower pixel pairs from the front bank, banks swap on frame_sync.
module glm_framebuffer #(
  parameter int COLS = 32,
  parameter int ROWS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  glm_framebuffer_if.slave      bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS / 2);
  localparam int IW = $clog2(COLS * ROWS);
  localparam int AW = RW + CW;
  localparam logic [IW-1:0] LAST_IDX = IW'(COLS * ROWS - 1);

  typedef enum logic [0:0] {FILL, WAIT_SWAP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          front_q, front_d;
  logic          disp_valid_q, disp_valid_d;
  logic          swap_q, swap_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_blank_q, rd_blank_d;
  logic          wr_accept;
  logic [5:0]    rd_pair;

  assign wr_accept = bus.wr_valid && (state_q == FILL);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    front_d      = front_q;
    disp_valid_d = disp_valid_q;
    swap_d       = 1'b0;
    err_d        = err_q;
    rd_valid_d   = bus.rd_en;
    rd_blank_d   = rd_blank_q;

    if (bus.rd_en) begin
      rd_blank_d = !disp_valid_q;
    end

    case (state_q)
      FILL: begin
        if (wr_accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = WAIT_SWAP;
            idx_d   = '0;
            if (!bus.wr_last) begin
              err_d = 1'b1;
            end
          end else if (bus.wr_last) begin
            // Early end-of-frame: flag it and resync so the next beat lands on pixel 0.
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (bus.frame_sync) begin
          state_d      = FILL;
          front_d      = ~front_q;
          disp_valid_d = 1'b1;
          swap_d       = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      idx_q        <= '0;
      front_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      swap_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_blank_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      front_q      <= front_d;
      disp_valid_q <= disp_valid_d;
      swap_q       <= swap_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      rd_blank_q   <= rd_blank_d;
    end
  end

  // One RAM per panel half, each holding both banks; the top index bit selects the half.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_half
    logic [2:0] mem [0:(2 << AW) - 1];
    logic [2:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_accept && (idx_q[IW-1] == 1'(gi))) begin
        mem[{~front_q, idx_q[AW-1:0]}] <= bus.wr_data;
      end
      if (bus.rd_en) begin
        rd_q <= mem[{front_q, bus.rd_row, bus.rd_col}];
      end
    end
  end

  assign rd_pair = {gen_half[0].rd_q, gen_half[1].rd_q};

  assign bus.wr_ready = (state_q == FILL);
  assign bus.rd_data  = rd_blank_q ? 6'b000000 : rd_pair;
  assign bus.rd_valid = rd_valid_q;
  assign bus.swap     = swap_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_glm_framebuffer.sv
// Scoreboard bench for glm_framebuffer: directed frames, reads queued with expected pixel pairs,
// a negedge monitor pops and compares each returned read.
module tb_glm_framebuffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  glm_framebuffer_if #(.COLS(32), .ROWS(16)) bus ();

  glm_framebuffer #(.COLS(32), .ROWS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int swap_seen = 0;
  logic [5:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every returned read is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.swap) swap_seen++;
      if (bus.rd_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: rd_valid with no queued read, rd_data=%b", bus.rd_data);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          if (bus.rd_data !== e) begin
            n_bad++;
            $display("FAIL rd_data: got %b, expected %b", bus.rd_data, e);
          end else begin
            $display("read ok: rd_data=%b", bus.rd_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] row, input logic [4:0] col, input logic [5:0] e);
    bus.rd_en  = 1'b1;
    bus.rd_row = row;
    bus.rd_col = col;
    exp_q.push_back(e);
    tick();
    bus.rd_en = 1'b0;
    tick();
  endtask

  // One accepted write beat; optionally reads row 3 col 5 in the same cycle.
  task automatic beat(input logic [2:0] d, input logic last, input logic do_rd, input logic [5:0] e);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    if (do_rd) begin
      bus.rd_en  = 1'b1;
      bus.rd_row = 3'd3;
      bus.rd_col = 5'd5;
      exp_q.push_back(e);
    end
    if (bus.wr_ready !== 1'b1) check("wr_ready_on_beat", int'(bus.wr_ready), 1);
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic sync_pulse();
    bus.frame_sync = 1'b1;
    tick();
    bus.frame_sync = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 0; bus.wr_data = 0; bus.wr_last = 0; bus.frame_sync = 0;
    bus.rd_en = 0; bus.rd_row = 0; bus.rd_col = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and blank read
    check("reset_wr_ready", int'(bus.wr_ready), 1);
    check("reset_err", int'(bus.err), 0);
    check("reset_swap", int'(bus.swap), 0);
    check("reset_rd_valid", int'(bus.rd_valid), 0);
    rd(3'd0, 5'd0, 6'b000000);

    // Frame A: data = idx % 8
    for (int i = 0; i < 512; i++) beat(3'(i % 8), i == 511, 1'b0, 6'b0);
    check("A_wr_ready_after_last", int'(bus.wr_ready), 0);
    check("A_err", int'(bus.err), 0);

    // Backpressure: beats of 7 offered for 100 cycles must all be refused
    bus.wr_valid = 1'b1;
    bus.wr_data  = 3'b111;
    for (int i = 0; i < 100; i++) begin
      if (i % 25 == 0) check("bp_wr_ready", int'(bus.wr_ready), 0);
      tick();
    end
    bus.wr_valid = 1'b0;
    rd(3'd0, 5'd0, 6'b000000);
    sync_pulse();
    check("A_swap_pulse", int'(bus.swap), 1);
    check("A_wr_ready_back", int'(bus.wr_ready), 1);
    tick();
    check("A_swap_one_cycle", int'(bus.swap), 0);
    rd(3'd3, 5'd5, 6'b101101);
    rd(3'd0, 5'd0, 6'b000000);
    rd(3'd7, 5'd31, 6'b111111);
    rd(3'd1, 5'd2, 6'b010010);

    // Frame B: all 7s while row 3 col 5 is read every beat; frame A must stay visible
    for (int i = 0; i < 512; i++) beat(3'b111, i == 511, 1'b1, 6'b101101);
    bus.rd_en = 1'b1; bus.rd_row = 3'd3; bus.rd_col = 5'd5;
    exp_q.push_back(6'b101101);
    sync_pulse();
    exp_q.push_back(6'b111111);
    tick();
    bus.rd_en = 1'b0;
    tick();

    // Framing error: wr_last on beat 100, then a full frame with distinct halves
    for (int i = 0; i <= 100; i++) beat(3'b001, i == 100, 1'b0, 6'b0);
    check("err_early_last", int'(bus.err), 1);
    check("err_still_filling", int'(bus.wr_ready), 1);
    for (int i = 0; i < 512; i++)
      beat((i < 256) ? 3'(i % 8) : 3'(7 - (i % 8)), i == 511, 1'b0, 6'b0);
    check("C_wr_ready_after_last", int'(bus.wr_ready), 0);
    sync_pulse();
    check("C_swap_pulse", int'(bus.swap), 1);
    check("C_err_sticky", int'(bus.err), 1);
    rd(3'd0, 5'd0, 6'b000111);
    rd(3'd3, 5'd5, 6'b101010);
    rd(3'd2, 5'd1, 6'b001110);

    // frame_sync during FILL is ignored, then reset lands on beat 200
    for (int i = 0; i < 50; i++) beat(3'b000, 1'b0, 1'b0, 6'b0);
    sync_pulse();
    check("fill_sync_no_swap", int'(bus.swap), 0);
    rd(3'd3, 5'd5, 6'b101010);
    for (int i = 50; i < 200; i++) beat(3'b000, 1'b0, 1'b0, 6'b0);
    bus.wr_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    check("rst_err_cleared", int'(bus.err), 0);
    rd(3'd3, 5'd5, 6'b000000);

    // Frame D from idx 0; frame_sync coincides with the final beat and must not swap
    for (int i = 0; i < 511; i++) beat(3'(i % 8), 1'b0, 1'b0, 6'b0);
    bus.frame_sync = 1'b1;
    beat(3'b111, 1'b1, 1'b0, 6'b0);
    bus.frame_sync = 1'b0;
    check("D_no_swap_on_last", int'(bus.swap), 0);
    check("D_wr_ready_after_last", int'(bus.wr_ready), 0);
    tick();
    check("D_no_late_swap", int'(bus.swap), 0);
    rd(3'd0, 5'd1, 6'b000000);
    sync_pulse();
    check("D_swap_pulse", int'(bus.swap), 1);
    rd(3'd0, 5'd1, 6'b001001);
    rd(3'd7, 5'd31, 6'b111111);
    rd(3'd4, 5'd6, 6'b110110);
    check("D_err_clear", int'(bus.err), 0);

    repeat (4) tick();
    check("total_swaps", swap_seen, 4);
    check("reads_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
